// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder
//   Stand-in DRP target mimicking the XADC primitive for the VAUX6/VAUX7
//   conversion-result registers, plus three read/write config registers.
//   One transaction is outstanding at a time. drdy_out pulses a fixed
//   READ_LATENCY cycles after the accepted den_in.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   daddr_in/den_in/dwe_in/di_in : DRP request (sampled with den_in)
//   do_out/drdy_out     : DRP read data and completion pulse (registered)
//   sample_x_in/_y_in   : 12-bit samples, loaded on sample_valid_in
//   busy_out            : transaction outstanding (incl. drdy cycle)
//   err_out             : sticky flag, den_in seen while busy
module xadc_drp_responder #(
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  daddr_in,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  input  logic [11:0] sample_x_in,
  input  logic [11:0] sample_y_in,
  input  logic        sample_valid_in,
  output logic        busy_out,
  output logic        err_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [15:0] cfg_q [3];
  logic [11:0] res_x_q, res_y_q;
  logic [15:0] do_q;
  logic        drdy_q, busy_q, err_q;

  logic        go_done;
  logic [15:0] rd_mux;
  logic        fin_we;
  logic [6:0]  fin_addr;
  logic [15:0] fin_wdata, fin_rdata;

  // Read data from the registers as they stand this cycle, so a same-cycle
  // sample_valid_in update is not yet visible.
  always_comb begin
    rd_mux = '0;
    case (daddr_in)
      7'h16:   rd_mux = {res_x_q, 4'h0};
      7'h17:   rd_mux = {res_y_q, 4'h0};
      7'h3F:   rd_mux = {15'h0, err_q};
      7'h40:   rd_mux = cfg_q[0];
      7'h41:   rd_mux = cfg_q[1];
      7'h42:   rd_mux = cfg_q[2];
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (den_in) begin
          cnt_d = 4'(READ_LATENCY - 1);
          if (READ_LATENCY == 1) begin
            state_d = S_DONE;
            go_done = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // cnt==1 here means the next cycle is the drdy cycle.
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          go_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Completion is registered on the edge entering S_DONE. With a latency of
  // one that is the accepting edge itself, so the request comes straight
  // from the inputs instead of the capture registers.
  always_comb begin
    if (state_q == S_IDLE) begin
      fin_we    = dwe_in;
      fin_addr  = daddr_in;
      fin_wdata = di_in;
      fin_rdata = rd_mux;
    end else begin
      fin_we    = we_q;
      fin_addr  = addr_q;
      fin_wdata = wdata_q;
      fin_rdata = rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int unsigned i = 0; i < 3; i++) cfg_q[i] <= '0;
      res_x_q <= '0;
      res_y_q <= '0;
      do_q    <= '0;
      drdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
      drdy_q  <= go_done;

      if (sample_valid_in) begin
        res_x_q <= sample_x_in;
        res_y_q <= sample_y_in;
      end

      if (den_in && state_q == S_IDLE) begin
        addr_q  <= daddr_in;
        we_q    <= dwe_in;
        wdata_q <= di_in;
        rdata_q <= rd_mux;
      end

      if (den_in && state_q != S_IDLE) err_q <= 1'b1;

      if (go_done) begin
        if (fin_we) begin
          case (fin_addr)
            7'h40:   cfg_q[0] <= fin_wdata;
            7'h41:   cfg_q[1] <= fin_wdata;
            7'h42:   cfg_q[2] <= fin_wdata;
            default: ;
          endcase
        end else begin
          do_q <= fin_rdata;
        end
      end
    end
  end

  assign do_out   = do_q;
  assign drdy_out = drdy_q;
  assign busy_out = busy_q;
  assign err_out  = err_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
module tb_xadc_drp_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: READ_LATENCY=4 instance, index 1: READ_LATENCY=1 instance.
  logic        rst  [2];
  logic [6:0]  addr [2];
  logic        den  [2];
  logic        we   [2];
  logic [15:0] di   [2];
  logic [15:0] dout [2];
  logic        drdy [2];
  logic [11:0] sx   [2];
  logic [11:0] sy   [2];
  logic        sv   [2];
  logic        busy [2];
  logic        err  [2];

  xadc_drp_responder #(.READ_LATENCY(4)) dut4 (
    .clk(clk), .reset(rst[0]), .daddr_in(addr[0]), .den_in(den[0]),
    .dwe_in(we[0]), .di_in(di[0]), .do_out(dout[0]), .drdy_out(drdy[0]),
    .sample_x_in(sx[0]), .sample_y_in(sy[0]), .sample_valid_in(sv[0]),
    .busy_out(busy[0]), .err_out(err[0]));

  xadc_drp_responder #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst[1]), .daddr_in(addr[1]), .den_in(den[1]),
    .dwe_in(we[1]), .di_in(di[1]), .do_out(dout[1]), .drdy_out(drdy[1]),
    .sample_x_in(sx[1]), .sample_y_in(sy[1]), .sample_valid_in(sv[1]),
    .busy_out(busy[1]), .err_out(err[1]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural register contents per instance.
  logic [15:0] m_cfg [2][3];
  logic [11:0] m_rx  [2];
  logic [11:0] m_ry  [2];
  logic        m_err [2];
  logic [15:0] m_do  [2];

  function automatic int lat(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [15:0] model_read(input int d, input logic [6:0] a);
    if (a == 7'h16) return {m_rx[d], 4'h0};
    if (a == 7'h17) return {m_ry[d], 4'h0};
    if (a == 7'h3F) return {15'h0, m_err[d]};
    if (a >= 7'h40 && a <= 7'h42) return m_cfg[d][a - 7'h40];
    return 16'h0000;
  endfunction

  task automatic model_reset(input int d);
    for (int i = 0; i < 3; i++) m_cfg[d][i] = 16'h0000;
    m_rx[d] = '0; m_ry[d] = '0; m_err[d] = 1'b0; m_do[d] = 16'h0000;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs(input int d);
    den[d] = 1'b0; we[d] = 1'b0; sv[d] = 1'b0;
  endtask

  task automatic pulse_sample(input int d, input logic [11:0] x, input logic [11:0] y);
    @(negedge clk);
    sv[d] = 1'b1; sx[d] = x; sy[d] = y;
    m_rx[d] = x; m_ry[d] = y;
    @(negedge clk);
    sv[d] = 1'b0;
  endtask

  // One DRP transaction. Optionally a same-cycle sample update, an illegal
  // den_in injected at wait cycle 'inj', and random sample traffic while busy.
  task automatic txn(input int d, input logic [6:0] a, input logic w,
                     input logic [15:0] data, input logic do_sv,
                     input logic [11:0] x, input logic [11:0] y,
                     input int inj, input logic rnd_sv);
    int L;
    logic [15:0] exp_rd;
    L = lat(d);
    @(negedge clk);
    check("idle_busy", 16'(busy[d]), 16'h0);
    check("idle_drdy", 16'(drdy[d]), 16'h0);
    exp_rd = model_read(d, a);
    addr[d] = a; we[d] = w; di[d] = data; den[d] = 1'b1;
    sv[d] = do_sv; sx[d] = x; sy[d] = y;
    if (do_sv) begin m_rx[d] = x; m_ry[d] = y; end
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      clear_inputs(d);
      check("busy", 16'(busy[d]), 16'h1);
      check("drdy", 16'(drdy[d]), 16'(k == L));
      if (k == L) begin
        if (!w) m_do[d] = exp_rd;
        else if (a >= 7'h40 && a <= 7'h42) m_cfg[d][a - 7'h40] = data;
        check("do_out", dout[d], m_do[d]);
        check("err", 16'(err[d]), 16'(m_err[d]));
      end else begin
        if (k == inj) begin
          den[d] = 1'b1; we[d] = 1'b1; addr[d] = 7'h40; di[d] = 16'($urandom);
          m_err[d] = 1'b1;
        end
        if (rnd_sv && $urandom_range(0, 2) == 0) begin
          sv[d] = 1'b1; sx[d] = 12'($urandom); sy[d] = 12'($urandom);
          m_rx[d] = sx[d]; m_ry[d] = sy[d];
        end
      end
    end
  endtask

  task automatic read(input int d, input logic [6:0] a);
    txn(d, a, 1'b0, 16'h0, 1'b0, 12'h0, 12'h0, 0, 1'b0);
  endtask

  task automatic write(input int d, input logic [6:0] a, input logic [15:0] data);
    txn(d, a, 1'b1, data, 1'b0, 12'h0, 12'h0, 0, 1'b0);
  endtask

  // Write accepted at cycle t, reset asserted during cycle t+2.
  task automatic reset_mid_write(input int d, input logic [6:0] a, input logic [15:0] data);
    @(negedge clk);
    addr[d] = a; we[d] = 1'b1; di[d] = data; den[d] = 1'b1;
    @(negedge clk);
    clear_inputs(d);
    @(negedge clk);
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    model_reset(d);
    for (int k = 0; k < 4; k++) begin
      check("rst_busy", 16'(busy[d]), 16'h0);
      check("rst_drdy", 16'(drdy[d]), 16'h0);
      @(negedge clk);
    end
    check("rst_do", dout[d], 16'h0);
    check("rst_err", 16'(err[d]), 16'h0);
  endtask

  task automatic random_txns(input int d, input int n);
    logic [6:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 7))
        0: a = 7'h16;
        1: a = 7'h17;
        2: a = 7'h3F;
        3: a = 7'h40;
        4: a = 7'h41;
        5: a = 7'h42;
        default: a = 7'($urandom);
      endcase
      txn(d, a, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
          12'($urandom), 12'($urandom),
          ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b1);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; addr[d] = '0; di[d] = '0; sx[d] = '0; sy[d] = '0;
      clear_inputs(d);
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_do",   dout[d], 16'h0);
      check("reset_drdy", 16'(drdy[d]), 16'h0);
      check("reset_busy", 16'(busy[d]), 16'h0);
      check("reset_err",  16'(err[d]), 16'h0);
    end

    // Latency-4 instance: result registers.
    pulse_sample(0, 12'hABC, 12'h123);
    read(0, 7'h16);
    check("tp_res_x", dout[0], 16'hABC0);
    read(0, 7'h17);
    check("tp_res_y", dout[0], 16'h1230);

    // Config write then readback.
    write(0, 7'h41, 16'h5A5A);
    check("tp_wr_keeps_do", dout[0], 16'h1230);
    read(0, 7'h41);
    check("tp_cfg1", dout[0], 16'h5A5A);
    read(0, 7'h40);
    check("tp_cfg0", dout[0], 16'h0000);

    // Same-cycle sample update returns the old value.
    pulse_sample(0, 12'h111, 12'h0);
    txn(0, 7'h16, 1'b0, 16'h0, 1'b1, 12'h222, 12'h0, 0, 1'b0);
    check("tp_old_sample", dout[0], 16'h1110);
    read(0, 7'h16);
    check("tp_new_sample", dout[0], 16'h2220);

    // den_in during the wait phase.
    txn(0, 7'h16, 1'b0, 16'h0, 1'b0, 12'h0, 12'h0, 2, 1'b0);
    check("tp_err_set", 16'(err[0]), 16'h1);
    read(0, 7'h3F);
    check("tp_err_reg", dout[0], 16'h0001);

    // Reset mid-write discards the write.
    reset_mid_write(0, 7'h40, 16'hFFFF);
    read(0, 7'h40);
    check("tp_rst_cfg0", dout[0], 16'h0000);

    random_txns(0, 40);

    // Latency-1 instance.
    write(1, 7'h42, 16'hC3C3);
    read(1, 7'h42);
    check("l1_cfg2", dout[1], 16'hC3C3);
    read(1, 7'h05);
    check("l1_unmapped", dout[1], 16'h0000);
    pulse_sample(1, 12'h7E5, 12'h01A);
    read(1, 7'h17);
    check("l1_res_y", dout[1], 16'h01A0);
    random_txns(1, 40);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
